// File: rtl/write_slave_mngr.sv
// Slave-side AXI write endpoint: takes one AW, gathers four 32-bit W beats into a 128-bit line,
// commits the line to memory and answers with a B response carrying the request ID.
module write_slave_mngr (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         awvalid_i,
    output logic         awready_o,
    input  logic [3:0]   awid_i,
    input  logic [31:0]  awaddr_i,
    input  logic [5:0]   awatop_i,
    input  logic         wvalid_i,
    output logic         wready_o,
    input  logic [31:0]  wdata_i,
    input  logic         wlast_i,
    output logic         bvalid_o,
    input  logic         bready_i,
    output logic [3:0]   bid_o,
    output logic         bcomp_o,
    output logic         mem_we_o,
    output logic [27:0]  mem_addr_o,
    output logic [127:0] mem_wdata_o,
    input  logic         mem_wready_i
);

    typedef enum logic [1:0] {StIdle, StData, StMemWr, StResp} state_e;

    state_e         state_q, state_d;
    logic [3:0]     id_q, id_d;
    logic [27:0]    addr_q, addr_d;
    logic           err_q, err_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [127:0]   line_q, line_d;

    // Byte offset within the line carries no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^awaddr_i[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        unique case (state_q)
            StIdle: begin
                if (awvalid_i) begin
                    id_d    = awid_i;
                    addr_d  = awaddr_i[31:4];
                    err_d   = (awatop_i != 6'd0);
                    cnt_d   = 2'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (wvalid_i) begin
                    line_d[{cnt_q, 5'd0} +: 32] = wdata_i;
                    cnt_d = cnt_q + 2'd1;
                    // The fourth beat always closes the burst; a missing wlast there is an error.
                    if (cnt_q == 2'd3) begin
                        if (err_q || !wlast_i) begin
                            err_d   = 1'b1;
                            state_d = StResp;
                        end else begin
                            state_d = StMemWr;
                        end
                    end else if (wlast_i) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StMemWr: begin
                if (mem_wready_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign awready_o   = (state_q == StIdle);
    assign wready_o    = (state_q == StData);
    assign mem_we_o    = (state_q == StMemWr);
    assign bvalid_o    = (state_q == StResp);
    assign bid_o       = id_q;
    assign bcomp_o     = bvalid_o & ~err_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = line_q;

endmodule
